// File: rtl/sync_pkg.sv
// Shared types and default sizing for the synchroniser TX-side arbiter.
package sync_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_N           = 4;
  localparam int DEF_STALL_LIMIT = 64;
  localparam int XFER_W          = 16;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req at or above ptr, wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0] s;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    s      = '0;
    for (int i = 0; i < N; i++) begin
      // ptr < N and i < N, so one subtraction is enough to wrap.
      s = {1'b0, ptr} + (IW+1)'(i);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      if (!any && req[s[IW-1:0]]) begin
        onehot[s[IW-1:0]] = 1'b1;
        idx               = s[IW-1:0];
        any               = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sync_tx_arbiter.sv
// Round-robin arbiter that feeds one word at a time into the synchroniser TX half.
module sync_tx_arbiter
  import sync_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N           = DEF_N,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic [WIDTH-1:0]     tx_in,
  output logic                 tx_valid,
  input  logic                 tx_send,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 stall,
  output logic [XFER_W-1:0]    xfer_count
);
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STALL_LIMIT);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [SW-1:0] stall_cnt;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          take;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Ready is only offered from IDLE, so a capture can never coincide with a transfer.
  assign take      = (state == IDLE) && en && !rst && pick_any;
  assign req_ready = take ? pick_onehot : '0;
  assign busy      = (state == HOLD);
  assign stall     = (stall_cnt == SLIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_in      <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      xfer_count <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          state     <= HOLD;
          tx_valid  <= 1'b1;
          tx_in     <= req_data[pick_idx*WIDTH +: WIDTH];
          grant_id  <= pick_idx;
          stall_cnt <= '0;
        end
        HOLD: if (tx_send) begin
          state      <= IDLE;
          tx_valid   <= 1'b0;
          rr_ptr     <= (grant_id == IW'(N-1)) ? '0 : grant_id + 1'b1;
          xfer_count <= xfer_count + 1'b1;
          stall_cnt  <= '0;
        end else if (stall_cnt != SLIM) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
